// File: rtl/xs_if.sv
// xs_if: bundle for the s/x/g start-count-acknowledge initiator.
//   go, n_high : software start request and programmed x-high count
//   g          : acknowledge from the responder
//   s, x       : start pulse and count-enable stream to the responder
//   busy, done : transaction in flight / one-cycle end-of-transaction pulse
//   pass, fail : sticky result of the last transaction
//   sent       : x-high cycles emitted so far
// master = the generator, slave = whoever drives go/n_high/g.
interface xs_if #(
    parameter int CNT_W = 5
) ();
    logic             go;
    logic [CNT_W-1:0] n_high;
    logic             g;
    logic             s;
    logic             x;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] sent;

    modport master (
        input  go, n_high, g,
        output s, x, busy, done, pass, fail, sent
    );

    modport slave (
        output go, n_high, g,
        input  s, x, busy, done, pass, fail, sent
    );
endinterface

// File: rtl/xs_stim_gen.sv
// xs_stim_gen: initiator for the s/x/g interface.
// On go (IDLE only) it pulses s for one cycle, emits n_high x-high cycles
// in runs of at most RUN_LEN separated by single x-low gaps, then waits up
// to TMO cycles for g. done pulses once at the end with pass or fail held.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : xs_if.master (go, n_high, g in; s, x, busy, done, pass, fail, sent out)
// All outputs are flops; s/x/busy/done are registered from the next state
// so they line up with the state they describe.
module xs_stim_gen #(
    parameter int CNT_W   = 5,
    parameter int RUN_LEN = 4,
    parameter int TMO     = 8
) (
    input logic  clk,
    input logic  reset,
    xs_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] WAIT_G = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    localparam logic [3:0] RUN_LAST = 4'(RUN_LEN - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] sent_r;
    logic [3:0]       run_cnt;
    logic [7:0]       tmo_cnt;
    logic             last_hi;
    logic             run_full;
    logic             tmo_hit;

    // last_hi has priority over run_full so no gap trails the final high cycle
    assign last_hi  = (sent_r == n_lat - CNT_W'(1));
    assign run_full = (run_cnt == RUN_LAST);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.go) nxt = START;
            START:   nxt = (n_lat != '0) ? RUN : WAIT_G;
            RUN: begin
                if (last_hi)       nxt = WAIT_G;
                else if (run_full) nxt = GAP;
            end
            GAP:     nxt = RUN;
            WAIT_G:  if (bus.g || tmo_hit) nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            n_lat    <= '0;
            sent_r   <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            bus.s    <= 1'b0;
            bus.x    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail <= 1'b0;
        end else begin
            state    <= nxt;
            bus.s    <= (nxt == START);
            bus.x    <= (nxt == RUN);
            bus.busy <= (nxt != IDLE);
            bus.done <= (nxt == FIN);
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        n_lat    <= bus.n_high;
                        sent_r   <= '0;
                        run_cnt  <= '0;
                        tmo_cnt  <= '0;
                        bus.pass <= 1'b0;
                        bus.fail <= 1'b0;
                    end
                end
                RUN: begin
                    sent_r  <= sent_r + CNT_W'(1);
                    run_cnt <= (last_hi || run_full) ? 4'd0 : run_cnt + 4'd1;
                end
                WAIT_G: begin
                    // saturating: never wraps back into a fresh window
                    if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.g)        bus.pass <= 1'b1;
                    else if (tmo_hit) bus.fail <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sent = sent_r;
endmodule
